// File: rtl/alu_issue_wb.sv
// Issue/writeback wrapper: valid/ready instruction intake, register-file operand read,
// execute register driving the combinational alu, writeback register feeding result handshake.

module alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         a_or_l,
  input  logic         s_or_u,
  input  logic [2:0]   op_code,
  output logic [W-1:0] answer
);
  localparam int SW = $clog2(W);

  logic [SW-1:0] shamt;
  logic          lt;

  assign shamt = b[SW-1:0];
  assign lt    = s_or_u ? ($signed(a) < $signed(b)) : (a < b);

  // Unused opcodes in either group yield zero.
  always_comb begin
    answer = '0;
    if (a_or_l) begin
      case (op_code)
        3'd0:    answer = a & b;
        3'd1:    answer = a | b;
        3'd2:    answer = a ^ b;
        3'd3:    answer = ~(a | b);
        default: answer = '0;
      endcase
    end else begin
      case (op_code)
        3'd0:    answer = a + b;
        3'd1:    answer = a - b;
        3'd2:    answer = {{(W-1){1'b0}}, lt};
        3'd3:    answer = a << shamt;
        3'd4:    answer = a >> shamt;
        3'd5:    answer = W'($signed(a) >>> shamt);
        default: answer = '0;
      endcase
    end
  end
endmodule

module alu_issue_wb #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              cfg_we,
  input  logic [REG_AW-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_rd
);
  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] rf [NREG];

  logic              in_a_or_l, in_s_or_u;
  logic [2:0]        in_op;
  logic [REG_AW-1:0] in_rd, in_rs1, in_rs2;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              unused_instr_bits;

  logic              x_valid, x_a_or_l, x_s_or_u;
  logic [2:0]        x_op;
  logic [REG_AW-1:0] x_rd;
  logic [DATA_W-1:0] x_a, x_b;
  logic [DATA_W-1:0] answer;

  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic [REG_AW-1:0] w_rd;

  logic              x_adv, hazard, accept;

  assign in_a_or_l         = in_instr[15];
  assign in_s_or_u         = in_instr[14];
  assign in_op             = in_instr[13:11];
  assign in_rd             = in_instr[8 +: REG_AW];
  assign in_rs1            = in_instr[5 +: REG_AW];
  assign in_rs2            = in_instr[2 +: REG_AW];
  assign unused_instr_bits = ^in_instr[1:0];

  assign rs1_data = (in_rs1 == '0) ? '0 : rf[in_rs1];
  assign rs2_data = (in_rs2 == '0) ? '0 : rf[in_rs2];

  // No forwarding: a source matching the in-flight destination waits until it is written back.
  assign x_adv    = x_valid & (~w_valid | res_ready);
  assign hazard   = x_valid & (x_rd != '0) & ((in_rs1 == x_rd) | (in_rs2 == x_rd));
  assign in_ready = (~x_valid | x_adv) & ~hazard;
  assign accept   = in_valid & in_ready;

  alu #(.W(DATA_W)) u_alu (
    .a       (x_a),
    .b       (x_b),
    .a_or_l  (x_a_or_l),
    .s_or_u  (x_s_or_u),
    .op_code (x_op),
    .answer  (answer)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      x_valid  <= 1'b0;
      x_a_or_l <= 1'b0;
      x_s_or_u <= 1'b0;
      x_op     <= '0;
      x_rd     <= '0;
      x_a      <= '0;
      x_b      <= '0;
      w_valid  <= 1'b0;
      w_data   <= '0;
      w_rd     <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (accept) begin
        x_valid  <= 1'b1;
        x_a_or_l <= in_a_or_l;
        x_s_or_u <= in_s_or_u;
        x_op     <= in_op;
        x_rd     <= in_rd;
        x_a      <= rs1_data;
        x_b      <= rs2_data;
      end else if (x_adv) begin
        x_valid <= 1'b0;
      end

      if (x_adv) begin
        w_valid <= 1'b1;
        w_data  <= answer;
        w_rd    <= x_rd;
      end else if (w_valid & res_ready) begin
        w_valid <= 1'b0;
      end

      // Writeback takes priority over a same-address preload; r0 is never written.
      for (int i = 1; i < NREG; i++) begin
        if (x_adv && (x_rd == REG_AW'(i)))
          rf[i] <= answer;
        else if (cfg_we && (cfg_addr == REG_AW'(i)))
          rf[i] <= cfg_data;
      end
    end
  end

  assign res_valid = w_valid;
  assign res_data  = w_data;
  assign res_rd    = w_rd;
endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb: directed instructions push expected results,
// a negedge monitor pops and compares on every result handshake.

module tb_alu_issue_wb;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_rd;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_issue_wb #(.DATA_W(32), .REG_AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd)
  );

  function automatic logic [15:0] mk(input logic al, input logic su, input logic [2:0] op,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [2:0] rs2);
    return {al, su, op, rd, rs1, rs2, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: a handshake seen at negedge completes on the following rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got data %0d rd %0d expected none", res_data, res_rd);
        end else begin
          e = sb.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_rd", 32'(res_rd), 32'(e.rd));
        end
      end
    end
  end

  task automatic present(input logic [15:0] ins, input logic [31:0] d, input logic [2:0] rd);
    sb.push_back('{data: d, rd: rd});
    in_instr = ins;
    in_valid = 1'b1;
  endtask

  // Returns at 1ns after the accepting edge; counts cycles spent waiting.
  task automatic wait_accept(output int stalls);
    bit ok = 0;
    stalls = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      stalls++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [31:0] d, input logic [2:0] rd,
                       output int stalls);
    present(ins, d, rd);
    wait_accept(stalls);
  endtask

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_res_data", res_data, 32'd0);
    chk("reset_res_rd", 32'(res_rd), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: preload and single ADD, latency check
    cfg(3'd1, 32'd64);
    cfg(3'd2, 32'd16);
    issue(mk(0, 0, 3'd0, 3'd3, 3'd1, 3'd2), 32'd80, 3'd3, st);
    @(negedge clk);
    chk("latency_not_early", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("latency_valid", 32'(res_valid), 32'd1);
    drain();

    // 2: RAW hazard costs exactly one bubble
    issue(mk(0, 0, 3'd0, 3'd3, 3'd1, 3'd2), 32'd80, 3'd3, st);
    issue(mk(0, 0, 3'd1, 3'd4, 3'd3, 3'd2), 32'd64, 3'd4, st);
    chk("hazard_stall", 32'(st), 32'd1);
    drain();

    // 3: independent logic ops stream without stall
    issue(mk(1, 0, 3'd0, 3'd5, 3'd1, 3'd2), 32'd0, 3'd5, st);
    issue(mk(1, 0, 3'd2, 3'd6, 3'd1, 3'd2), 32'd80, 3'd6, st);
    chk("no_stall", 32'(st), 32'd0);
    drain();

    // 4: backpressure holds W, fills X, then releases in order
    res_ready = 1'b0;
    issue(mk(1, 0, 3'd1, 3'd5, 3'd1, 3'd2), 32'd80, 3'd5, st);
    issue(mk(0, 0, 3'd0, 3'd6, 3'd1, 3'd1), 32'd128, 3'd6, st);
    chk("bp_second_no_stall", 32'(st), 32'd0);
    present(mk(0, 0, 3'd1, 3'd7, 3'd1, 3'd2), 32'd48, 3'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_data_held", res_data, 32'd80);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_accept(st);
    drain();

    // 5: rd=0 reported, r0 reads zero, writeback beats same-address cfg
    issue(mk(0, 0, 3'd0, 3'd0, 3'd1, 3'd2), 32'd80, 3'd0, st);
    issue(mk(0, 0, 3'd0, 3'd3, 3'd0, 3'd0), 32'd0, 3'd3, st);
    drain();
    issue(mk(0, 0, 3'd0, 3'd7, 3'd1, 3'd2), 32'd80, 3'd7, st);
    cfg(3'd7, 32'd999);
    issue(mk(0, 0, 3'd0, 3'd4, 3'd7, 3'd0), 32'd80, 3'd4, st);
    cfg(3'd0, 32'd55);
    issue(mk(1, 0, 3'd1, 3'd5, 3'd0, 3'd0), 32'd0, 3'd5, st);
    drain();

    // 6: reset with X and W full discards everything
    res_ready = 1'b0;
    issue(mk(0, 0, 3'd0, 3'd5, 3'd1, 3'd2), 32'd80, 3'd5, st);
    issue(mk(1, 0, 3'd1, 3'd6, 3'd1, 3'd2), 32'd80, 3'd6, st);
    @(negedge clk);
    chk("pre_reset_valid", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("post_reset_valid", 32'(res_valid), 32'd0);
    chk("post_reset_data", res_data, 32'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    issue(mk(0, 0, 3'd0, 3'd3, 3'd1, 3'd2), 32'd0, 3'd3, st);
    drain();
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
